tag_array_ctrl: RTL and testbench

Access controller for the 4-way, 64-set, 22-bit-per-way L1 tag SRAM, which has a single read/write port with a per-way write mask. It invalidates the array after reset and on flush, and arbitrates refill writes against lookups. For each lookup it produces a registered hit/way result plus a victim way on miss. It sits between the cache pipeline and the tag SRAM macro and drives the macro's only port.

---
 rtl/tag_array_ctrl_if.sv | 58 +++++
 rtl/tag_array_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_tag_array_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tag_array_ctrl_if.sv
// Pipeline-side bundle for the L1 tag array controller: lookup request,
// lookup response, refill write, flush request and sweep status.
interface tag_array_ctrl_if #(
  parameter int SETS  = 64,
  parameter int WAYS  = 4,
  parameter int TAG_W = 22
) ();

  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  // Lookup request
  logic               lk_valid;
  logic               lk_ready;
  logic [SET_W-1:0]   lk_set;
  logic [TAG_W-2:0]   lk_tag;

  // Lookup response (single-cycle pulse, no backpressure)
  logic               rsp_valid;
  logic               rsp_hit;
  logic [WAYS-1:0]    rsp_way;
  logic               rsp_multi;

  // Refill write
  logic               wr_valid;
  logic               wr_ready;
  logic [SET_W-1:0]   wr_set;
  logic [WAY_W-1:0]   wr_way;
  logic [TAG_W-2:0]   wr_tag;
  logic               wr_v;

  // Whole-array invalidation and sweep status
  logic               flush_req;
  logic               busy;

  // Cache pipeline side
  modport master (
    output lk_valid, lk_set, lk_tag,
    input  lk_ready,
    input  rsp_valid, rsp_hit, rsp_way, rsp_multi,
    output wr_valid, wr_set, wr_way, wr_tag, wr_v,
    input  wr_ready,
    output flush_req,
    input  busy
  );

  // Tag array controller side
  modport slave (
    input  lk_valid, lk_set, lk_tag,
    output lk_ready,
    output rsp_valid, rsp_hit, rsp_way, rsp_multi,
    input  wr_valid, wr_set, wr_way, wr_tag, wr_v,
    output wr_ready,
    input  flush_req,
    output busy
  );

endinterface

// File: rtl/tag_array_ctrl.sv
// Access controller for the single-port L1 tag SRAM. Clears the array after
// reset and on flush, arbitrates refill writes over lookups, and returns a
// registered hit/way result (victim way on miss) two cycles after a lookup.
module tag_array_ctrl #(
  parameter  int SETS  = 64,
  parameter  int WAYS  = 4,
  parameter  int TAG_W = 22,
  localparam int SET_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  tag_array_ctrl_if.slave       bus,
  output logic                  ram_en,
  output logic                  ram_wmode,
  output logic [SET_W-1:0]      ram_addr,
  output logic [WAYS*TAG_W-1:0] ram_wdata,
  output logic [WAYS-1:0]       ram_wmask,
  input  logic [WAYS*TAG_W-1:0] ram_rdata
);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [SET_W-1:0]  cnt_q, cnt_d;
  logic              started_q;

  logic              idle;
  logic              sweep;
  logic              wr_acc;
  logic              lk_acc;

  logic              s1_valid_q;
  logic [SET_W-1:0]  s1_set_q;
  logic [TAG_W-2:0]  s1_tag_q;

  logic [TAG_W-1:0]  entry [WAYS];
  logic [WAYS-1:0]   match;
  logic [WAYS-1:0]   invalid;
  logic [WAYS-1:0]   victim;
  logic              found;
  logic              hit;
  logic              multi;
  logic              all_valid;

  logic [WAY_W-1:0]  rr_q;

  logic              rsp_valid_q;
  logic              rsp_hit_q;
  logic [WAYS-1:0]   rsp_way_q;
  logic              rsp_multi_q;

  // The sweep only drives the SRAM once the first post-reset edge has passed,
  // so the port stays quiet while reset_n is held low.
  assign idle  = (state_q == ST_IDLE);
  assign sweep = (state_q == ST_FLUSH) || ((state_q == ST_INIT) && started_q);

  // Flush beats write beats lookup; a pending write also blocks lookups.
  assign bus.busy     = !idle;
  assign bus.wr_ready = idle && !bus.flush_req;
  assign bus.lk_ready = idle && !bus.flush_req && !bus.wr_valid;

  assign wr_acc = bus.wr_valid && bus.wr_ready;
  assign lk_acc = bus.lk_valid && bus.lk_ready;

  // Sweep sequencing: walk every set once, then settle in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT, ST_FLUSH: begin
        if (sweep) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == SET_W'(SETS - 1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_IDLE: begin
        if (bus.flush_req) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, sweep counter and the post-reset start flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      started_q <= 1'b1;
    end
  end

  // Single SRAM port: sweep clears, refill writes one masked way, lookup reads.
  always_comb begin
    ram_en    = 1'b0;
    ram_wmode = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wmask = '0;
    if (sweep) begin
      ram_en    = 1'b1;
      ram_wmode = 1'b1;
      ram_addr  = cnt_q;
      ram_wmask = '1;
    end else if (wr_acc) begin
      ram_en    = 1'b1;
      ram_wmode = 1'b1;
      ram_addr  = bus.wr_set;
      ram_wmask = WAYS'(1) << bus.wr_way;
      ram_wdata = {WAYS{bus.wr_v, bus.wr_tag}};
    end else if (lk_acc) begin
      ram_en    = 1'b1;
      ram_addr  = bus.lk_set;
    end
  end

  // Stage 1 holds the lookup key while the SRAM read data comes back.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_set_q   <= '0;
      s1_tag_q   <= '0;
    end else begin
      s1_valid_q <= lk_acc;
      if (lk_acc) begin
        s1_set_q <= bus.lk_set;
        s1_tag_q <= bus.lk_tag;
      end
    end
  end

  // Per-way compare; a same-set write landing this cycle overrides the stale read.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      entry[w] = ram_rdata[w*TAG_W +: TAG_W];
      if (wr_acc && (bus.wr_set == s1_set_q) && (bus.wr_way == WAY_W'(w))) begin
        entry[w] = {bus.wr_v, bus.wr_tag};
      end
      match[w]   = entry[w][TAG_W-1] && (entry[w][TAG_W-2:0] == s1_tag_q);
      invalid[w] = !entry[w][TAG_W-1];
    end
  end

  assign hit       = |match;
  assign multi     = ($countones(match) > 1);
  assign all_valid = !(|invalid);

  // Victim choice: lowest invalid way, else the round-robin way.
  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (invalid[w] && !found) begin
        victim[w] = 1'b1;
        found     = 1'b1;
      end
    end
    if (!found) begin
      victim = WAYS'(1) << rr_q;
    end
  end

  // Round-robin pointer moves only when it actually picked the victim.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_q <= '0;
    end else if (s1_valid_q && !hit && all_valid) begin
      rr_q <= rr_q + 1'b1;
    end
  end

  // Registered response: valid pulses one cycle, payload held between lookups.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_way_q   <= '0;
      rsp_multi_q <= 1'b0;
    end else begin
      rsp_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        rsp_hit_q   <= hit;
        rsp_way_q   <= hit ? match : victim;
        rsp_multi_q <= multi;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_hit   = rsp_hit_q;
  assign bus.rsp_way   = rsp_way_q;
  assign bus.rsp_multi = rsp_multi_q;

endmodule

// File: tb/tb_tag_array_ctrl.sv
// Directed self-checking bench for tag_array_ctrl with a behavioural tag SRAM.
module tb_tag_array_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ram_en;
  logic        ram_wmode;
  logic [5:0]  ram_addr;
  logic [87:0] ram_wdata;
  logic [3:0]  ram_wmask;
  logic [87:0] ram_rdata = '0;

  logic [87:0] mem [64];
  logic [87:0] mergedWord;

  int checkCount = 0;
  int errorCount = 0;

  tag_array_ctrl_if bus ();

  tag_array_ctrl dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .ram_en    (ram_en),
    .ram_wmode (ram_wmode),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wmask (ram_wmask),
    .ram_rdata (ram_rdata)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clock = ~clock;

  // Behavioural single-port SRAM with per-way write mask and 1-cycle read
  always @(posedge clock) begin
    if (ram_en) begin
      if (ram_wmode) begin
        mergedWord = mem[ram_addr];
        for (int w = 0; w < 4; w++) begin
          if (ram_wmask[w]) mergedWord[w*22 +: 22] = ram_wdata[w*22 +: 22];
        end
        mem[ram_addr] <= mergedWord;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  // Hard stop in case the sequence never reaches its summary
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic waitCycle();
    @(posedge clock);
    #1;
  endtask

  // Checks 64 consecutive clearing writes starting in the current cycle
  task automatic checkSweep(input string name);
    for (int i = 0; i < 64; i++) begin
      #1;
      checkOutput(name,
        128'({ram_en, ram_wmode, ram_wmask, ram_addr, bus.busy, bus.lk_ready, bus.wr_ready, (ram_wdata == 88'd0)}),
        128'({1'b1, 1'b1, 4'hF, 6'(i), 1'b1, 1'b0, 1'b0, 1'b1}));
      waitCycle();
    end
    #1;
    checkOutput({name, "_done"}, 128'(bus.busy), 128'(1'b0));
  endtask

  // One refill write, checked on the SRAM port in its accept cycle
  task automatic applyWrite(input logic [5:0] set, input logic [1:0] way, input logic [20:0] tag,
                            input logic v, input string name);
    logic [3:0] expMask;
    expMask = 4'b0001 << way;
    bus.wr_valid = 1'b1;
    bus.wr_set   = set;
    bus.wr_way   = way;
    bus.wr_tag   = tag;
    bus.wr_v     = v;
    #1;
    checkOutput({name, "_wr"},
      128'({bus.wr_ready, ram_en, ram_wmode, ram_addr, ram_wmask}),
      128'({1'b1, 1'b1, 1'b1, set, expMask}));
    checkOutput({name, "_wdata"}, 128'(ram_wdata), 128'({4{v, tag}}));
    waitCycle();
    bus.wr_valid = 1'b0;
  endtask

  // Isolated lookup; response is checked two cycles after accept
  task automatic applyLookup(input logic [5:0] set, input logic [20:0] tag, input logic expHit,
                             input logic [3:0] expWay, input logic expMulti, input string name);
    bus.lk_valid = 1'b1;
    bus.lk_set   = set;
    bus.lk_tag   = tag;
    #1;
    checkOutput({name, "_ready"}, 128'(bus.lk_ready), 128'(1'b1));
    waitCycle();
    bus.lk_valid = 1'b0;
    #1;
    checkOutput({name, "_early"}, 128'(bus.rsp_valid), 128'(1'b0));
    waitCycle();
    #1;
    checkOutput({name, "_rsp"},
      128'({bus.rsp_valid, bus.rsp_hit, bus.rsp_way, bus.rsp_multi}),
      128'({1'b1, expHit, expWay, expMulti}));
  endtask

  initial begin
    logic [3:0] expWay;

    reset_n       = 1'b0;
    bus.lk_valid  = 1'b1;
    bus.lk_set    = 6'd0;
    bus.lk_tag    = 21'h155;
    bus.wr_valid  = 1'b0;
    bus.wr_set    = '0;
    bus.wr_way    = '0;
    bus.wr_tag    = '0;
    bus.wr_v      = 1'b0;
    bus.flush_req = 1'b0;
    for (int s = 0; s < 64; s++) mem[s] = '0;

    // Reset values
    repeat (2) @(posedge clock);
    #2;
    checkOutput("rst_busy",      128'(bus.busy),      128'(1'b1));
    checkOutput("rst_lk_ready",  128'(bus.lk_ready),  128'(1'b0));
    checkOutput("rst_wr_ready",  128'(bus.wr_ready),  128'(1'b0));
    checkOutput("rst_rsp_valid", 128'(bus.rsp_valid), 128'(1'b0));
    checkOutput("rst_rsp_hit",   128'(bus.rsp_hit),   128'(1'b0));
    checkOutput("rst_rsp_way",   128'(bus.rsp_way),   128'(4'h0));
    checkOutput("rst_rsp_multi", 128'(bus.rsp_multi), 128'(1'b0));
    checkOutput("rst_ram_en",    128'(ram_en),        128'(1'b0));
    checkOutput("rst_ram_wmode", 128'(ram_wmode),     128'(1'b0));
    checkOutput("rst_ram_wmask", 128'(ram_wmask),     128'(4'h0));
    checkOutput("rst_ram_addr",  128'(ram_addr),      128'(6'd0));
    checkOutput("rst_ram_wdata", 128'(ram_wdata),     128'(88'd0));

    // Init sweep with lookup held, then first lookup misses to way 0
    reset_n = 1'b1;
    waitCycle();
    checkSweep("init");
    checkOutput("first_accept",
      128'({bus.lk_ready, ram_en, ram_wmode, ram_addr}),
      128'({1'b1, 1'b1, 1'b0, 6'd0}));
    waitCycle();
    bus.lk_valid = 1'b0;
    #1;
    checkOutput("first_early", 128'(bus.rsp_valid), 128'(1'b0));
    waitCycle();
    #1;
    checkOutput("first_rsp",
      128'({bus.rsp_valid, bus.rsp_hit, bus.rsp_way, bus.rsp_multi}),
      128'({1'b1, 1'b0, 4'b0001, 1'b0}));
    waitCycle();
    #1;
    checkOutput("first_pulse", 128'(bus.rsp_valid), 128'(1'b0));

    // Write then lookup
    applyWrite(6'd5, 2'd2, 21'h1ABCD, 1'b1, "w5");
    applyLookup(6'd5, 21'h1ABCD, 1'b1, 4'b0100, 1'b0, "hit5");

    // Bypass: lookup in N, same-set write in N+1
    bus.lk_valid = 1'b1;
    bus.lk_set   = 6'd9;
    bus.lk_tag   = 21'h7;
    #1;
    checkOutput("byp_ready", 128'(bus.lk_ready), 128'(1'b1));
    waitCycle();
    bus.lk_valid = 1'b0;
    applyWrite(6'd9, 2'd1, 21'h7, 1'b1, "byp");
    #1;
    checkOutput("byp_rsp",
      128'({bus.rsp_valid, bus.rsp_hit, bus.rsp_way, bus.rsp_multi}),
      128'({1'b1, 1'b1, 4'b0010, 1'b0}));

    // Victim round-robin on a full set, back-to-back misses
    for (int w = 0; w < 4; w++) applyWrite(6'd3, 2'(w), 21'(32'h100 + w), 1'b1, "fill");
    for (int i = 0; i < 6; i++) begin
      bus.lk_valid = (i < 4);
      bus.lk_set   = 6'd3;
      bus.lk_tag   = 21'h3FF;
      if (i >= 2) begin
        #1;
        expWay = 4'b0001 << (i - 2);
        checkOutput("rr_rsp",
          128'({bus.rsp_valid, bus.rsp_hit, bus.rsp_way, bus.rsp_multi}),
          128'({1'b1, 1'b0, expWay, 1'b0}));
      end
      waitCycle();
    end

    // Multi-hit, then invalidate one copy
    applyWrite(6'd12, 2'd0, 21'h155, 1'b1, "m0");
    applyWrite(6'd12, 2'd3, 21'h155, 1'b1, "m3");
    applyLookup(6'd12, 21'h155, 1'b1, 4'b1001, 1'b1, "multi");
    applyWrite(6'd12, 2'd3, 21'h155, 1'b0, "inv3");
    applyLookup(6'd12, 21'h155, 1'b1, 4'b0001, 1'b0, "single");

    // Write wins over a simultaneous lookup
    bus.wr_valid = 1'b1;
    bus.wr_set   = 6'd20;
    bus.wr_way   = 2'd0;
    bus.wr_tag   = 21'h33;
    bus.wr_v     = 1'b1;
    bus.lk_valid = 1'b1;
    bus.lk_set   = 6'd21;
    bus.lk_tag   = 21'h0;
    #1;
    checkOutput("arb",
      128'({bus.lk_ready, bus.wr_ready, ram_wmode, ram_addr}),
      128'({1'b0, 1'b1, 1'b1, 6'd20}));
    waitCycle();
    bus.wr_valid = 1'b0;
    bus.lk_valid = 1'b0;
    waitCycle();
    #1;
    checkOutput("arb_no_rsp", 128'(bus.rsp_valid), 128'(1'b0));

    // Flush behind an in-flight lookup; flush also beats a write
    bus.lk_valid = 1'b1;
    bus.lk_set   = 6'd5;
    bus.lk_tag   = 21'h1ABCD;
    #1;
    checkOutput("fl_lk_ready", 128'(bus.lk_ready), 128'(1'b1));
    waitCycle();
    bus.lk_valid  = 1'b0;
    bus.flush_req = 1'b1;
    bus.wr_valid  = 1'b1;
    bus.wr_set    = 6'd7;
    bus.wr_tag    = 21'h55;
    #1;
    checkOutput("fl_block",
      128'({bus.wr_ready, bus.lk_ready, ram_en, bus.busy}),
      128'({1'b0, 1'b0, 1'b0, 1'b0}));
    waitCycle();
    bus.flush_req = 1'b0;
    bus.wr_valid  = 1'b0;
    #1;
    checkOutput("fl_inflight",
      128'({bus.rsp_valid, bus.rsp_hit, bus.rsp_way, bus.rsp_multi}),
      128'({1'b1, 1'b1, 4'b0100, 1'b0}));
    checkSweep("flush");
    applyLookup(6'd5, 21'h1ABCD, 1'b0, 4'b0001, 1'b0, "postflush");

    // Reset pulled mid-sweep restarts INIT from set 0
    bus.flush_req = 1'b1;
    waitCycle();
    bus.flush_req = 1'b0;
    repeat (20) waitCycle();
    #1;
    checkOutput("mid_sweep", 128'({ram_addr, bus.busy}), 128'({6'd20, 1'b1}));
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst",
      128'({ram_en, ram_wmode, ram_wmask, ram_addr, bus.busy, bus.lk_ready, bus.wr_ready, bus.rsp_valid}),
      128'({1'b0, 1'b0, 4'h0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0}));
    waitCycle();
    waitCycle();
    reset_n = 1'b1;
    waitCycle();
    checkSweep("reinit");

    // Reset with a lookup in flight drops its response
    bus.lk_valid = 1'b1;
    bus.lk_set   = 6'd5;
    bus.lk_tag   = 21'h1ABCD;
    #1;
    checkOutput("drop_ready", 128'(bus.lk_ready), 128'(1'b1));
    waitCycle();
    bus.lk_valid = 1'b0;
    reset_n      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("drop_no_rsp", 128'(bus.rsp_valid), 128'(1'b0));
      waitCycle();
    end
    reset_n = 1'b1;
    waitCycle();
    checkSweep("reinit2");

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
